// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start/data/parity/stop framing around an external
// serializer, with a cross-check of the serializer's last-bit flag against an internal count.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic                  ser_data,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT,
    output logic                  sync_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_bit, cfg_par_en, cfg_stop2;
    logic             last_bit, data_exit;

    assign last_bit  = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    // Either source ends the data phase; disagreement between them is flagged, not fatal.
    assign data_exit = ser_done || last_bit;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (Data_Valid) next_state = ST_START;
            ST_START:  next_state = ST_DATA;
            ST_DATA:   if (data_exit) next_state = cfg_par_en ? ST_PARITY : ST_STOP1;
            ST_PARITY: next_state = ST_STOP1;
            ST_STOP1:  next_state = cfg_stop2 ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            cfg_par_en <= 1'b0;
            cfg_stop2  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != ST_IDLE);
            if (state == ST_IDLE && Data_Valid) begin
                par_bit    <= (^P_DATA) ^ PAR_TYP;
                cfg_par_en <= PAR_EN;
                cfg_stop2  <= STOP2;
            end
            if (state == ST_START)
                bit_cnt <= '0;
            else if (state == ST_DATA)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign ser_en   = (state == ST_DATA);
    assign sync_err = (state == ST_DATA) && (ser_done ^ last_bit);

    // Line mux draws only on registered sources, so it cannot glitch within a bit.
    always_comb begin
        TX_OUT = 1'b1;
        case (state)
            ST_START:  TX_OUT = 1'b0;
            ST_DATA:   TX_OUT = ser_data;
            ST_PARITY: TX_OUT = par_bit;
            default:   TX_OUT = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a stub serializer feeds the DUT, and a per-cycle scoreboard of
// {TX_OUT, busy, ser_en, sync_err} is built from each frame request and drained as the line runs.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Data_Valid = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
    logic       ser_data, ser_done;
    logic       ser_en, busy, TX_OUT, sync_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic tx;
        logic busy;
        logic en;
        logic err;
    } exp_t;

    exp_t exp_q[$];

    // Stub serializer: load on acceptance, shift LSB-first while enabled.
    // done_mode: 0 = natural flag on 8th bit, 1 = early flag on 5th bit, 2 = flag stuck low.
    logic [7:0] sreg;
    logic [3:0] scnt;
    int         done_mode = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= 8'h00;
            scnt <= 4'd0;
        end else begin
            if (Data_Valid && !busy) sreg <= P_DATA;
            else if (ser_en)         sreg <= {1'b0, sreg[7:1]};
            scnt <= ser_en ? scnt + 4'd1 : 4'd0;
        end
    end

    assign ser_data = sreg[0];
    assign ser_done = (done_mode == 0) ? (ser_en && scnt == 4'd7) :
                      (done_mode == 1) ? (ser_en && scnt == 4'd4) : 1'b0;

    uart_tx_ctrl #(.DATA_WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .ser_data(ser_data), .ser_done(ser_done),
        .ser_en(ser_en), .busy(busy), .TX_OUT(TX_OUT), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Request one frame, queue the expected per-cycle line state, then drain while sampling.
    // inject_at >= 0 pulses Data_Valid with 0xFF and flipped config at that frame cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic pe, input logic pt,
                             input logic s2, input int mode, input int inject_at, input int idle_after);
        exp_t e, got;
        int   ones, nd, cyc;
        @(negedge clk);
        Data_Valid = 1'b1; P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        done_mode = mode;
        nd = (mode == 1) ? 5 : 8;
        ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        exp_q.push_back('{tx: 1'b0, busy: 1'b1, en: 1'b0, err: 1'b0});
        for (int i = 0; i < nd; i++)
            exp_q.push_back('{tx: d[i], busy: 1'b1, en: 1'b1,
                              err: (mode == 1 && i == 4) || (mode == 2 && i == 7)});
        if (pe) exp_q.push_back('{tx: ((ones % 2) == 1) != pt, busy: 1'b1, en: 1'b0, err: 1'b0});
        exp_q.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b0, err: 1'b0});
        if (s2) exp_q.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b0, err: 1'b0});
        for (int i = 0; i < idle_after; i++)
            exp_q.push_back('{tx: 1'b1, busy: 1'b0, en: 1'b0, err: 1'b0});
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            got = '{tx: TX_OUT, busy: busy, en: ser_en, err: sync_err};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s cyc %0d: got tx/busy/en/err=%b want %b", tag, cyc, got, e);
            end
            if (cyc == inject_at) begin
                Data_Valid = 1'b1; P_DATA = 8'hFF;
                PAR_EN = ~pe; PAR_TYP = ~pt; STOP2 = ~s2;
            end else begin
                Data_Valid = 1'b0;
            end
            cyc++;
        end
        Data_Valid = 1'b0;
        done_mode = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({TX_OUT, busy, ser_en, sync_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset: got tx/busy/en/err=%b want 1000", {TX_OUT, busy, ser_en, sync_err});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({TX_OUT, busy, ser_en, sync_err} !== 4'b1000) begin
            errors++;
            $display("FAIL post_reset_idle: got %b want 1000", {TX_OUT, busy, ser_en, sync_err});
        end
    endtask

    task automatic test_parity_frames();
        run_frame("a5_even_stop1", 8'hA5, 1'b1, 1'b0, 1'b0, 0, -1, 2);
        run_frame("a5_odd_stop2",  8'hA5, 1'b1, 1'b1, 1'b1, 0, -1, 2);
        run_frame("c1_odd_stop1",  8'hC1, 1'b1, 1'b1, 1'b0, 0, -1, 1);
    endtask

    task automatic test_ignore_busy();
        run_frame("zero_nopar_inject", 8'h00, 1'b0, 1'b0, 1'b0, 0, 3, 4);
    endtask

    task automatic test_sync_err();
        run_frame("early_done_par", 8'h3C, 1'b1, 1'b0, 1'b0, 1, -1, 1);
        run_frame("early_done_nopar", 8'h96, 1'b0, 1'b0, 1'b1, 1, -1, 1);
        run_frame("stuck_done_low", 8'h5A, 1'b1, 1'b0, 1'b0, 2, -1, 1);
    endtask

    task automatic test_mid_reset();
        exp_t e, got;
        @(negedge clk);
        Data_Valid = 1'b1; P_DATA = 8'hE7; PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
        exp_q.push_back('{tx: 1'b0, busy: 1'b1, en: 1'b0, err: 1'b0});
        exp_q.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b1, err: 1'b0});
        exp_q.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b1, err: 1'b0});
        exp_q.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b1, err: 1'b0});
        exp_q.push_back('{tx: 1'b0, busy: 1'b1, en: 1'b1, err: 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Data_Valid = 1'b0;
            e   = exp_q.pop_front();
            got = '{tx: TX_OUT, busy: busy, en: ser_en, err: sync_err};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mid_reset_pre cyc %0d: got %b want %b", i, got, e);
            end
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({TX_OUT, busy, ser_en, sync_err} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_reset_async: got %b want 1000", {TX_OUT, busy, ser_en, sync_err});
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        run_frame("after_reset", 8'h81, 1'b1, 1'b1, 1'b1, 0, -1, 1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first",  8'h4D, 1'b0, 1'b0, 1'b0, 0, -1, 0);
        run_frame("b2b_second", 8'hB2, 1'b1, 1'b0, 1'b0, 0, -1, 1);
    endtask

    initial begin
        test_reset();
        test_parity_frames();
        test_ignore_busy();
        test_sync_err();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
